// File: rtl/ramp_src.sv
// AXI4-Stream ramp test-pattern source: natural or PFB-processing order,
// optional D-of-M duty-cycle throttle, frame markers and finite run length.
module ramp_src #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned M        = 64,
  parameter int unsigned D        = 48,
  parameter string       ORDER    = "processing",
  parameter int unsigned THROTTLE = 0,
  parameter int unsigned PH_START = 0,
  parameter int unsigned NFRAMES  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_tlast,
  output logic [31:0]      frame_cnt,
  output logic             done
);

  localparam int unsigned IW       = $clog2(M);
  localparam bit          PROC     = (ORDER == "processing");
  localparam bit          THR_ON   = (THROTTLE != 0);
  localparam bit          LIMITED  = (NFRAMES != 0);
  localparam logic [IW-1:0]    LAST_IDX = IW'(M - 1);
  localparam logic [IW-1:0]    PH_RST   = IW'(PH_START);
  localparam logic [31:0]      LAST_FRM = 32'(NFRAMES - 1);
  localparam logic [WIDTH-1:0] FRM_STEP = WIDTH'(M);
  localparam logic [WIDTH-1:0] DATA_RST = PROC ? WIDTH'(M - 1) : '0;

  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] base_q, base_d;
  logic [IW-1:0]    ph_q, ph_d;
  logic             tvalid_q, tvalid_d;
  logic [WIDTH-1:0] tdata_q, tdata_d;
  logic             tlast_q, tlast_d;
  logic [31:0]      frame_cnt_q, frame_cnt_d;
  logic             done_q, done_d;

  logic hs;
  logic last_hs;
  logic slot_ok;
  logic start_ok;

  // Next-state: beat position, frame base, throttle phase and the presented beat
  always_comb begin
    idx_d       = idx_q;
    base_d      = base_q;
    ph_d        = ph_q;
    tvalid_d    = tvalid_q;
    frame_cnt_d = frame_cnt_q;
    done_d      = done_q;

    hs      = tvalid_q & m_axis_tready;
    last_hs = hs & (idx_q == LAST_IDX);
    slot_ok = !THR_ON || (32'(ph_q) < D);

    // Phase runs off en only, so stalled beats still use up window slots
    if (THR_ON && en) begin
      ph_d = ph_q + IW'(1);
    end

    if (hs) begin
      idx_d = idx_q + IW'(1);
    end

    if (last_hs) begin
      base_d      = base_q + FRM_STEP;
      frame_cnt_d = frame_cnt_q + 32'd1;
      if (LIMITED && (frame_cnt_q == LAST_FRM)) begin
        done_d = 1'b1;
      end
    end

    start_ok = en & ~done_d & slot_ok;

    // A presented beat is held until accepted; only then may a new one start
    if (!tvalid_q || hs) begin
      tvalid_d = start_ok;
    end

    tdata_d = PROC ? (base_d + WIDTH'(LAST_IDX - idx_d)) : (base_d + WIDTH'(idx_d));
    tlast_d = (idx_d == LAST_IDX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q       <= '0;
      base_q      <= '0;
      ph_q        <= PH_RST;
      tvalid_q    <= 1'b0;
      tdata_q     <= DATA_RST;
      tlast_q     <= 1'b0;
      frame_cnt_q <= '0;
      done_q      <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      base_q      <= base_d;
      ph_q        <= ph_d;
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      tlast_q     <= tlast_d;
      frame_cnt_q <= frame_cnt_d;
      done_q      <= done_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_tlast       = tlast_q;
  assign frame_cnt     = frame_cnt_q;
  assign done          = done_q;

endmodule

// File: tb/tb_ramp_src.sv
// Random en/tready bench for ramp_src: two configurations checked each cycle
// against a beat-count reference model, plus async reset and throttle window checks.
module tb_ramp_src;

  localparam int unsigned W = 8;
  localparam int unsigned M = 16;

  // instance 0: processing order, throttled, unlimited; instance 1: natural, free, 5 frames
  localparam int unsigned D_K   [2] = '{12, 16};
  localparam int unsigned PH_K  [2] = '{3, 0};
  localparam int unsigned THR_K [2] = '{1, 0};
  localparam int unsigned PROC_K[2] = '{1, 0};
  localparam int unsigned NF_K  [2] = '{0, 5};

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic tready;

  logic [W-1:0] tdata0, tdata1;
  logic         tvalid0, tvalid1, tlast0, tlast1, done0, done1;
  logic [31:0]  fcnt0, fcnt1;

  int total = 0;
  int bad   = 0;

  int unsigned m_n [2];
  int unsigned m_ph[2];
  bit          m_v [2];
  bit          m_dn[2];

  always #5 clk = ~clk;

  ramp_src #(.WIDTH(W), .M(M), .D(12), .ORDER("processing"), .THROTTLE(1),
             .PH_START(3), .NFRAMES(0)) u0 (
    .clk(clk), .rst(rst), .en(en),
    .m_axis_tdata(tdata0), .m_axis_tvalid(tvalid0), .m_axis_tready(tready),
    .m_tlast(tlast0), .frame_cnt(fcnt0), .done(done0));

  ramp_src #(.WIDTH(W), .M(M), .D(16), .ORDER("natural"), .THROTTLE(0),
             .PH_START(0), .NFRAMES(5)) u1 (
    .clk(clk), .rst(rst), .en(en),
    .m_axis_tdata(tdata1), .m_axis_tvalid(tvalid1), .m_axis_tready(tready),
    .m_tlast(tlast1), .frame_cnt(fcnt1), .done(done1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_data(input int k);
    int unsigned n, f, i, v;
    n = m_n[k];
    f = n / M;
    i = n % M;
    v = (PROC_K[k] != 0) ? (f * M + M - 1 - i) : n;
    return 32'(v % (1 << W));
  endfunction

  function automatic logic [31:0] exp_last(input int k);
    return 32'((m_n[k] % M) == M - 1);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_n[k]  = 0;
      m_ph[k] = PH_K[k];
      m_v[k]  = 1'b0;
      m_dn[k] = 1'b0;
    end
  endtask

  // One clock edge of the reference: count accepted beats, apply start rule, advance phase
  task automatic model_step();
    bit hs;
    for (int k = 0; k < 2; k++) begin
      hs = m_v[k] && tready;
      if (hs) begin
        m_n[k]++;
        if (NF_K[k] != 0 && m_n[k] == NF_K[k] * M) m_dn[k] = 1'b1;
      end
      if (!m_v[k] || hs)
        m_v[k] = en && !m_dn[k] && (THR_K[k] == 0 || m_ph[k] < D_K[k]);
      if (en) m_ph[k] = (m_ph[k] + 1) % M;
    end
  endtask

  task automatic check_outputs();
    check("tvalid0", 32'(tvalid0), 32'(m_v[0]));
    check("tdata0",  32'(tdata0),  exp_data(0));
    check("tlast0",  32'(tlast0),  exp_last(0));
    check("fcnt0",   fcnt0,        m_n[0] / M);
    check("done0",   32'(done0),   32'(m_dn[0]));
    check("tvalid1", 32'(tvalid1), 32'(m_v[1]));
    check("tdata1",  32'(tdata1),  exp_data(1));
    check("tlast1",  32'(tlast1),  exp_last(1));
    check("fcnt1",   fcnt1,        m_n[1] / M);
    check("done1",   32'(done1),   32'(m_dn[1]));
  endtask

  task automatic check_reset_vals();
    check("rst_tvalid0", 32'(tvalid0), 32'd0);
    check("rst_tdata0",  32'(tdata0),  32'(M - 1));
    check("rst_tlast0",  32'(tlast0),  32'd0);
    check("rst_tvalid1", 32'(tvalid1), 32'd0);
    check("rst_tdata1",  32'(tdata1),  32'd0);
    check("rst_fcnt1",   fcnt1,        32'd0);
    check("rst_done1",   32'(done1),   32'd0);
  endtask

  initial begin
    int win_hs;
    rst    = 1'b1;
    en     = 1'b0;
    tready = 1'b0;
    model_reset();
    #3;
    check_reset_vals();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    win_hs = 0;

    for (int cyc = 0; cyc < 1600; cyc++) begin
      check_outputs();

      // 16-cycle window in steady full-rate traffic: throttled source gets exactly D beats
      if (cyc >= 100 && cyc < 116 && tvalid0 && tready) win_hs++;
      if (cyc == 116) check("win_hs0", 32'(win_hs), 32'd12);

      // Asynchronous reset between edges, observed before any clock edge
      if (cyc == 300 || cyc == 907 || cyc == 1213) begin
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
      end

      if (cyc < 300 || cyc >= 1213) begin
        en     = 1'b1;
        tready = 1'b1;
      end else begin
        en     = ($urandom_range(0, 99) < 85);
        tready = ($urandom_range(0, 99) < 70);
      end

      @(posedge clk);
      model_step();
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
